// File: rtl/dst_signature_collector.sv
// dst_signature_collector: registers dst, folds a capture window into a MISR signature and shifts it out serially.
// Optional SIG_PARALLEL_EN adds the sig_par port holding the final signature.
module dst_signature_collector #(
   parameter int                   DST_WIDTH   = 36,
   parameter int                   SIG_WIDTH   = 32,
   parameter logic [SIG_WIDTH-1:0] POLY        = SIG_WIDTH'(32'h04C11DB7),
   parameter logic [SIG_WIDTH-1:0] SEED        = SIG_WIDTH'(32'hFFFFFFFF),
   parameter int                   WARMUP      = 31,
   parameter int                   CAPTURE_LEN = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [DST_WIDTH-1:0] dst,
   output logic                 busy,
   output logic                 sig_out,
   output logic                 sig_valid,
   input  logic                 sig_ready,
   output logic                 done
`ifdef SIG_PARALLEL_EN
   ,
   output logic [SIG_WIDTH-1:0] sig_par
`endif
);
   localparam int NCH     = (DST_WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;
   localparam int CNT_MAX = WARMUP > CAPTURE_LEN ? WARMUP : CAPTURE_LEN;
   localparam int CW      = CNT_MAX > 1 ? $clog2(CNT_MAX) : 1;
   localparam int BW      = $clog2(SIG_WIDTH);
   localparam logic [CW-1:0] WARM_LAST = CW'(WARMUP - 1);
   localparam logic [CW-1:0] CAP_LAST  = CW'(CAPTURE_LEN - 1);
   typedef enum logic [2:0] {S_IDLE, S_WARM, S_ACCUM, S_SHIFT, S_DONE} state_t;
   state_t                   r_state, w_next;
   logic [DST_WIDTH-1:0]     r_dst_q;
   logic [SIG_WIDTH-1:0]     r_misr, w_fold, w_misr_next;
   logic [NCH*SIG_WIDTH-1:0] w_pad;
   logic [CW-1:0]            r_cnt;
   logic [BW-1:0]            r_bit_idx;
   logic                     r_arm, w_start, w_warm_last, w_cap_last, w_last_bit;
   // r_arm stays low for the first edge after reset release so a start there is ignored
   assign w_start     = start && r_arm && r_state == S_IDLE;
   assign w_warm_last = r_cnt == WARM_LAST;
   assign w_cap_last  = r_cnt == CAP_LAST;
   assign w_last_bit  = sig_ready && r_bit_idx == '0;
   assign w_pad       = (NCH*SIG_WIDTH)'(r_dst_q);
   always_comb begin
      w_fold = '0;
      for (int i = 0; i < NCH; i++)
         w_fold = w_fold ^ w_pad[i*SIG_WIDTH +: SIG_WIDTH];
   end
   assign w_misr_next = {r_misr[SIG_WIDTH-2:0], 1'b0} ^ (r_misr[SIG_WIDTH-1] ? POLY : '0) ^ w_fold;
   always_comb begin
      w_next    = r_state;
      busy      = r_state != S_IDLE;
      sig_valid = r_state == S_SHIFT;
      sig_out   = r_state == S_SHIFT ? r_misr[r_bit_idx] : 1'b0;
      done      = r_state == S_DONE;
      case (r_state)
         S_IDLE:  if (w_start) w_next = WARMUP == 0 ? S_ACCUM : S_WARM;
         S_WARM:  if (w_warm_last) w_next = S_ACCUM;
         S_ACCUM: if (w_cap_last) w_next = S_SHIFT;
         S_SHIFT: if (w_last_bit) w_next = S_DONE;
         default: w_next = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= S_IDLE;
      else r_state <= w_next;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dst_q   <= '0;
         r_misr    <= '0;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_arm     <= 1'b0;
      end else begin
         r_dst_q <= dst;
         r_arm   <= 1'b1;
         case (r_state)
            S_IDLE:  if (w_start) begin
               r_misr <= SEED;
               r_cnt  <= '0;
            end
            S_WARM:  r_cnt <= w_warm_last ? '0 : r_cnt + 1'b1;
            S_ACCUM: begin
               r_misr    <= w_misr_next;
               r_cnt     <= w_cap_last ? '0 : r_cnt + 1'b1;
               r_bit_idx <= w_cap_last ? BW'(SIG_WIDTH - 1) : r_bit_idx;
            end
            S_SHIFT: if (sig_ready && r_bit_idx != '0) r_bit_idx <= r_bit_idx - 1'b1;
            default: ;
         endcase
      end
   end
`ifdef SIG_PARALLEL_EN
   logic [SIG_WIDTH-1:0] r_sig_par;
   always_ff @(posedge clk or posedge rst)
      if (rst) r_sig_par <= '0;
      else if (r_state == S_SHIFT && w_last_bit) r_sig_par <= r_misr;
   assign sig_par = r_sig_par;
`endif
endmodule
